// File: rtl/btn_event_frontend.sv
// btn_event_frontend
//   Player-input front end: 2-flop synchronizer, per-button debounce,
//   rising-edge press pulses, and a FIFO of pressed button indices that
//   the game FSM drains over a valid/ready handshake.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   btn_raw[7:0] asynchronous button inputs, active-high
//   clear        flush pending mask, FIFO and overflow (debounce untouched)
//   btn_level    debounced button levels
//   btn_press    one-cycle pulse on a debounced 0->1 transition
//   event_valid  FIFO non-empty
//   event_id     button index at the FIFO head
//   event_ready  consumer accepts the head when high with event_valid
//   overflow     sticky: a press was coalesced into an already-pending one
module btn_event_frontend #(
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] btn_raw,
    input  logic       clear,
    output logic [7:0] btn_level,
    output logic [7:0] btn_press,
    output logic       event_valid,
    output logic [2:0] event_id,
    input  logic       event_ready,
    output logic       overflow
);
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    // Synchronizer and debounce state
    logic [7:0]       sync1;
    logic [7:0]       sync2;
    logic [7:0][15:0] cnt;
    logic [7:0][15:0] cnt_next;
    logic [7:0]       level_next;

    // Event queue state
    logic [7:0]                  pending;
    logic [FIFO_DEPTH-1:0][2:0]  mem;
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic [PTR_W:0]              count;

    logic       pop;
    logic       push;
    logic       found;
    logic [2:0] push_idx;
    logic [7:0] push_mask;

    // Debounce: a level flips only after DEBOUNCE_CYCLES consecutive
    // disagreeing synchronized samples; any agreeing sample restarts the run.
    always_comb begin
        level_next = btn_level;
        cnt_next   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (sync2[i] != btn_level[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    level_next[i] = sync2[i];
                end else begin
                    cnt_next[i] = cnt[i] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            cnt       <= '0;
            btn_level <= '0;
            btn_press <= '0;
        end else begin
            sync1     <= btn_raw;
            sync2     <= sync1;
            cnt       <= cnt_next;
            btn_level <= level_next;
            btn_press <= level_next & ~btn_level;
        end
    end

    assign event_valid = (count != '0);
    assign event_id    = mem[rd_ptr];
    assign pop         = event_valid && event_ready;

    // Encoder: lowest pending index goes first. A full FIFO still accepts
    // when the head leaves in the same cycle.
    always_comb begin
        found    = 1'b0;
        push_idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (pending[i] && !found) begin
                found    = 1'b1;
                push_idx = 3'(i);
            end
        end
        push      = found && ((count != DEPTH_C) || pop);
        push_mask = push ? (8'd1 << push_idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            overflow <= 1'b0;
            mem      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (clear) begin
            pending  <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            pending <= (pending & ~push_mask) | btn_press;
            // A press landing on a bit that stays pending is merged and lost.
            if ((btn_press & pending & ~push_mask) != '0) begin
                overflow <= 1'b1;
            end
            if (push) begin
                mem[wr_ptr] <= push_idx;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
